// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF write port between WB and the long-latency unit; `define RF_SCOREBOARD_EN adds the busy scoreboard
module rf_write_arbiter #(
  parameter int RR_EN    = 0,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic [63:0]      wb_data,
  output logic             wb_ready,
  input  logic             lu_valid,
  input  logic [4:0]       lu_reg,
  input  logic [63:0]      lu_data,
  output logic             lu_ready,
  output logic [4:0]       WriteReg,
  output logic [63:0]      WriteData,
  output logic             RegWrite,
`ifdef RF_SCOREBOARD_EN
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_reg,
  output logic [31:0]      busy,
`endif
  output logic [CNT_W-1:0] wait_cnt
);
  typedef enum logic [1:0] {PREF_WB, PREF_LU, FORCE_LU} stateT;
  stateT state, nextState;
  logic wbXfer, luXfer, commit;
  logic [4:0] selReg;
  logic atMax;
  assign atMax  = wait_cnt == CNT_W'(MAX_WAIT);
  assign wbXfer = wb_valid && wb_ready;
  assign luXfer = lu_valid && lu_ready;
  assign selReg = luXfer ? lu_reg : wb_reg;
  assign commit = (wbXfer || luXfer) && selReg != 5'd31;
  // grant selection and next preference; a starved LU forces unless it is served this cycle
  always_comb begin
    wb_ready  = 1'b0;
    lu_ready  = 1'b0;
    nextState = state;
    wb_ready  = wb_valid && (state == PREF_WB || (state == PREF_LU && !lu_valid));
    lu_ready  = lu_valid && (state != PREF_WB || !wb_valid);
    nextState = (atMax && !luXfer) ? FORCE_LU :
                state == FORCE_LU ? (luXfer ? PREF_WB : FORCE_LU) :
                RR_EN == 0 ? PREF_WB :
                wbXfer ? PREF_LU :
                luXfer ? PREF_WB : state;
  end
  // arbitration state register
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) state <= PREF_WB;
    else state <= nextState;
  // LU starvation counter, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) wait_cnt <= '0;
    else wait_cnt <= (luXfer || !lu_valid) ? '0 : atMax ? wait_cnt : wait_cnt + CNT_W'(1);
  // registered RF write port; XZR transfers are consumed without a commit
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= commit;
      if (commit) begin
        WriteReg  <= selReg;
        WriteData <= luXfer ? lu_data : wb_data;
      end
    end
`ifdef RF_SCOREBOARD_EN
  logic [31:0] setMask, clrMask;
  assign setMask = alloc_valid ? 32'd1 << alloc_reg : '0;
  assign clrMask = RegWrite ? 32'd1 << WriteReg : '0;
  // busy bits: allocation wins over a same-cycle commit; X31 never busy
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) busy <= '0;
    else busy <= ((busy & ~clrMask) | setMask) & 32'h7FFF_FFFF;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed bench for fixed-priority and round-robin instances against a behavioural model
module tb_rf_write_arbiter;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic Reset, wbV, luV;
  logic [4:0] wbReg, luReg;
  logic [63:0] wbData, luData;
  logic [1:0] wbRdy, luRdy, rw;
  logic [4:0] wr [2];
  logic [63:0] wd [2];
  logic [3:0] wc [2];
`ifdef RF_SCOREBOARD_EN
  logic allocV;
  logic [4:0] allocReg;
  logic [31:0] busy [2];
  logic [31:0] mBusy [2];
`endif
  int mWait [2];
  bit mForced [2], mLuTurn [2], mRw [2];
  logic [4:0] mWr [2];
  logic [63:0] mWd [2];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  rf_write_arbiter #(.RR_EN(0), .MAX_WAIT(MW), .CNT_W(4)) u0 (
    .clk(clk), .Reset(Reset),
    .wb_valid(wbV), .wb_reg(wbReg), .wb_data(wbData), .wb_ready(wbRdy[0]),
    .lu_valid(luV), .lu_reg(luReg), .lu_data(luData), .lu_ready(luRdy[0]),
    .WriteReg(wr[0]), .WriteData(wd[0]), .RegWrite(rw[0]),
`ifdef RF_SCOREBOARD_EN
    .alloc_valid(allocV), .alloc_reg(allocReg), .busy(busy[0]),
`endif
    .wait_cnt(wc[0]));
  rf_write_arbiter #(.RR_EN(1), .MAX_WAIT(MW), .CNT_W(4)) u1 (
    .clk(clk), .Reset(Reset),
    .wb_valid(wbV), .wb_reg(wbReg), .wb_data(wbData), .wb_ready(wbRdy[1]),
    .lu_valid(luV), .lu_reg(luReg), .lu_data(luData), .lu_ready(luRdy[1]),
    .WriteReg(wr[1]), .WriteData(wd[1]), .RegWrite(rw[1]),
`ifdef RF_SCOREBOARD_EN
    .alloc_valid(allocV), .alloc_reg(allocReg), .busy(busy[1]),
`endif
    .wait_cnt(wc[1]));
  function automatic bit expWbR(int i);
    return mForced[i] ? 1'b0 : mLuTurn[i] ? (wbV && !luV) : wbV;
  endfunction
  function automatic bit expLuR(int i);
    return mForced[i] ? luV : mLuTurn[i] ? luV : (luV && !wbV);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mWait[i] = 0; mForced[i] = 0; mLuTurn[i] = 0; mRw[i] = 0; mWr[i] = '0; mWd[i] = '0;
`ifdef RF_SCOREBOARD_EN
      mBusy[i] = '0;
`endif
    end
  endtask
  task automatic stepModel();
    for (int i = 0; i < 2; i++) begin
      bit wx, lx;
      wx = wbV && expWbR(i);
      lx = luV && expLuR(i);
      if (mWait[i] == MW && !lx) mForced[i] = 1;
      else if (lx) begin mForced[i] = 0; mLuTurn[i] = 0; end
      else if (wx && i == 1) mLuTurn[i] = 1;
      mWait[i] = (lx || !luV) ? 0 : (mWait[i] < MW ? mWait[i] + 1 : MW);
`ifdef RF_SCOREBOARD_EN
      if (mRw[i]) mBusy[i][mWr[i]] = 1'b0;
      if (allocV) mBusy[i][allocReg] = 1'b1;
      mBusy[i][31] = 1'b0;
`endif
      mRw[i] = (wx || lx) && ((lx ? luReg : wbReg) != 5'd31);
      if (mRw[i]) begin
        mWr[i] = lx ? luReg : wbReg;
        mWd[i] = lx ? luData : wbData;
      end
    end
  endtask
  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.wb_ready", i), 64'(wbRdy[i]), 64'(expWbR(i)));
      chk($sformatf("u%0d.lu_ready", i), 64'(luRdy[i]), 64'(expLuR(i)));
      chk($sformatf("u%0d.RegWrite", i), 64'(rw[i]), 64'(mRw[i]));
      chk($sformatf("u%0d.WriteReg", i), 64'(wr[i]), 64'(mWr[i]));
      chk($sformatf("u%0d.WriteData", i), wd[i], mWd[i]);
      chk($sformatf("u%0d.wait_cnt", i), 64'(wc[i]), 64'(mWait[i]));
`ifdef RF_SCOREBOARD_EN
      chk($sformatf("u%0d.busy", i), 64'(busy[i]), 64'(mBusy[i]));
`endif
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!Reset) modelReset();
    else stepModel();
    #1;
  endtask
  task automatic cyc();
    sample();
    tick();
  endtask
  initial begin
    Reset = 1'b0; wbV = 1'b0; luV = 1'b0; wbReg = '0; luReg = '0; wbData = '0; luData = '0;
`ifdef RF_SCOREBOARD_EN
    allocV = 1'b0; allocReg = '0;
`endif
    modelReset();
    sample();
    chk("t1.RegWrite", 64'(rw[0]), 64'd0);
    chk("t1.WriteData", wd[0], 64'd0);
    tick();
    cyc();
    Reset = 1'b1;
    sample();
    chk("t1.wb_ready_idle", 64'(wbRdy[0]), 64'd0);
    chk("t1.lu_ready_idle", 64'(luRdy[1]), 64'd0);
    tick();
    wbV = 1; wbReg = 5; wbData = 64'hAA; luV = 1; luReg = 6; luData = 64'hBB;
    sample();
    chk("t2.wb_ready", 64'(wbRdy[0]), 64'd1);
    chk("t2.lu_ready", 64'(luRdy[0]), 64'd0);
    tick();
    wbV = 0; luV = 0;
    sample();
    chk("t2.RegWrite", 64'(rw[0]), 64'd1);
    chk("t2.WriteReg", 64'(wr[0]), 64'd5);
    chk("t2.WriteData", wd[0], 64'hAA);
    tick();
    wbV = 1; luV = 1;
    for (int k = 0; k < 7; k++) begin
      sample();
      chk($sformatf("t3.wait_cnt.%0d", k), 64'(wc[0]), 64'(k < 4 ? k : (k < 6 ? 4 : 0)));
      chk($sformatf("t3.lu_ready.%0d", k), 64'(luRdy[0]), 64'(k == 5));
      chk($sformatf("t3.wb_ready.%0d", k), 64'(wbRdy[0]), 64'(k != 5));
      if (k == 6) begin
        chk("t3.RegWrite", 64'(rw[0]), 64'd1);
        chk("t3.WriteReg", 64'(wr[0]), 64'd6);
        chk("t3.WriteData", wd[0], 64'hBB);
      end
      chk($sformatf("t4.lu_ready.%0d", k), 64'(luRdy[1]), 64'(k % 2 == 0));
      chk($sformatf("t4.RegWrite.%0d", k), 64'(rw[1]), 64'(k != 0));
      if (k != 0) chk($sformatf("t4.WriteReg.%0d", k), 64'(wr[1]), 64'(k % 2 ? 6 : 5));
      tick();
    end
    wbV = 0; luV = 0;
    cyc();
    wbV = 1; wbReg = 31; wbData = 64'hFF;
    sample();
    chk("t5.wb_ready", 64'(wbRdy[0]), 64'd1);
    tick();
    wbV = 0;
    sample();
    chk("t5.RegWrite", 64'(rw[0]), 64'd0);
    chk("t5.WriteReg", 64'(wr[0]), 64'd5);
    chk("t5.WriteData", wd[0], 64'hAA);
    tick();
    wbV = 1; luV = 1; wbReg = 9; luReg = 9; wbData = 64'h1; luData = 64'h2;
    cyc();
    wbV = 0;
    sample();
    chk("same.first", wd[0], 64'h1);
    tick();
    luV = 0;
    sample();
    chk("same.last_reg", 64'(wr[0]), 64'd9);
    chk("same.last_data", wd[0], 64'h2);
    tick();
`ifdef RF_SCOREBOARD_EN
    allocV = 1; allocReg = 7;
    cyc();
    allocV = 0;
    sample();
    chk("t6.busy_set", 64'(busy[0][7]), 64'd1);
    tick();
    wbV = 1; wbReg = 7; wbData = 64'h77;
    cyc();
    wbV = 0;
    sample();
    chk("t6.commit", 64'(rw[0]), 64'd1);
    chk("t6.busy_hold", 64'(busy[0][7]), 64'd1);
    tick();
    sample();
    chk("t6.busy_clr", 64'(busy[0][7]), 64'd0);
    tick();
    allocV = 1; allocReg = 7;
    cyc();
    allocV = 0; wbV = 1;
    cyc();
    wbV = 0; allocV = 1;
    sample();
    chk("t6.commit2", 64'(rw[0]), 64'd1);
    tick();
    allocV = 0;
    sample();
    chk("t6.set_wins", 64'(busy[0][7]), 64'd1);
    tick();
    allocV = 1; allocReg = 31;
    cyc();
    allocV = 0;
    sample();
    chk("t6.busy31", 64'(busy[0][31]), 64'd0);
    tick();
`endif
    wbV = 1; luV = 1; wbReg = 3; luReg = 4; wbData = 64'h33; luData = 64'h44;
    cyc();
    #2 Reset = 1'b0;
    modelReset();
    #1;
    chk("t1.async_RegWrite", 64'(rw[0]), 64'd0);
    chk("t1.async_WriteReg", 64'(wr[0]), 64'd0);
    chk("t1.async_WriteData", wd[0], 64'd0);
    chk("t1.async_wait_cnt", 64'(wc[0]), 64'd0);
    chk("t1.async_RegWrite_rr", 64'(rw[1]), 64'd0);
    wbV = 0; luV = 0;
    cyc();
    Reset = 1'b1;
    sample();
    chk("t1.post_wb_ready", 64'(wbRdy[0]), 64'd0);
    chk("t1.post_lu_ready", 64'(luRdy[0]), 64'd0);
    tick();
    wbV = 1; wbReg = 2; wbData = 64'h22;
    cyc();
    wbV = 0;
    sample();
    chk("post.RegWrite", 64'(rw[0]), 64'd1);
    chk("post.WriteReg", 64'(wr[0]), 64'd2);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
